// File: rtl/cf_math_pkg.sv
// Shared math helpers for sizing index and counter fields.
package cf_math_pkg;

   // Width needed to index num_idx items; at least one bit even for a single item.
   function automatic integer idx_width(input integer num_idx);
      return (num_idx > 1) ? $clog2(num_idx) : 1;
   endfunction

endpackage

// File: rtl/stream_credit_receiver_buffer.sv
// In-order circular store with wrap-compare pointers and an occupancy counter.
module stream_credit_receiver_buffer
   import cf_math_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 4,
   parameter int unsigned PtrWidth  = idx_width(Depth),
   parameter int unsigned CntWidth  = idx_width(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic [CntWidth-1:0]  count_o
);

   logic [DataWidth-1:0] mem [Depth];
   logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntWidth-1:0]  count_q, count_d;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
   endfunction

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntWidth'(1);
         2'b01:   count_d = count_q - CntWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/stream_credit_receiver.sv
// Receiver side of a credit link: buffers beats, returns one credit per downstream pop.
module stream_credit_receiver
   import cf_math_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 4,
   parameter int unsigned PtrWidth  = idx_width(Depth),
   parameter int unsigned CntWidth  = idx_width(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 credit_o,
   output logic [CntWidth-1:0]  usage_o,
   output logic                 overflow_o
);

   logic                count;
   logic [CntWidth-1:0] count_q;
   logic                full;
   logic                push;
   logic                pop;
   logic                credit_q;
   logic                overflow_q;

   assign count   = (count_q != '0);
   assign full    = (count_q == CntWidth'(Depth));
   assign valid_o = count;
   assign pop     = valid_o & ready_i;
   // A simultaneous pop frees the slot, so a full buffer can still take a beat.
   assign push    = valid_i & (~full | pop);

   stream_credit_receiver_buffer #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .PtrWidth  (PtrWidth),
      .CntWidth  (CntWidth)
   ) u_buffer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (data_i),
      .pop_i   (pop),
      .data_o  (data_o),
      .count_o (count_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         credit_q   <= pop;
         overflow_q <= overflow_q | (valid_i & full & ~pop);
      end
   end

   assign credit_o   = credit_q;
   assign overflow_o = overflow_q;
   assign usage_o    = count_q;

endmodule

// File: tb/tb_stream_credit_receiver.sv
// Directed bench for stream_credit_receiver with DataWidth=8, Depth=4.
module tb_stream_credit_receiver;

   localparam int unsigned DataWidth = 8;
   localparam int unsigned Depth     = 4;
   localparam int unsigned CntWidth  = 3;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 valid_i;
   logic [DataWidth-1:0] data_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [DataWidth-1:0] data_o;
   logic                 credit_o;
   logic [CntWidth-1:0]  usage_o;
   logic                 overflow_o;

   int n_checks = 0;
   int n_errors = 0;
   int n_credits;

   always #5 clk_i = ~clk_i;

   stream_credit_receiver #(
      .DataWidth (DataWidth),
      .Depth     (Depth)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .credit_o   (credit_o),
      .usage_o    (usage_o),
      .overflow_o (overflow_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are stable #1 after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic push_beat(input logic [7:0] d);
      valid_i = 1'b1;
      data_i  = d;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic fill4();
      for (int i = 1; i <= 4; i++) push_beat(8'(i));
   endtask

   initial begin
      rst_i   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      #2;
      do_reset();
      check("rst_valid", valid_o, 0);
      check("rst_usage", usage_o, 0);
      check("rst_credit", credit_o, 0);
      check("rst_overflow", overflow_o, 0);

      // 1: single beat, one-cycle latency
      push_beat(8'hA1);
      check("s1_valid", valid_o, 1);
      check("s1_data", data_o, 8'hA1);
      check("s1_usage", usage_o, 1);
      check("s1_credit", credit_o, 0);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("s1_credit_after_pop", credit_o, 1);
      check("s1_usage_empty", usage_o, 0);
      tick();
      check("s1_credit_single", credit_o, 0);

      // 2: fill then drain in order
      fill4();
      check("s2_usage_full", usage_o, 4);
      check("s2_credit_idle", credit_o, 0);
      ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("s2_valid", valid_o, 1);
         check("s2_data", data_o, i);
         tick();
         check("s2_credit", credit_o, 1);
      end
      ready_i = 1'b0;
      check("s2_usage_end", usage_o, 0);
      check("s2_valid_end", valid_o, 0);
      tick();
      check("s2_credit_end", credit_o, 0);

      // 3: push and pop together while full
      fill4();
      valid_i = 1'b1;
      data_i  = 8'h55;
      ready_i = 1'b1;
      check("s3_head", data_o, 8'h01);
      tick();
      valid_i = 1'b0;
      check("s3_usage", usage_o, 4);
      check("s3_overflow", overflow_o, 0);
      check("s3_credit", credit_o, 1);
      check("s3_d0", data_o, 8'h02);
      tick();
      check("s3_d1", data_o, 8'h03);
      tick();
      check("s3_d2", data_o, 8'h04);
      tick();
      check("s3_d3", data_o, 8'h55);
      tick();
      ready_i = 1'b0;
      check("s3_usage_end", usage_o, 0);
      check("s3_overflow_end", overflow_o, 0);

      // 4: overflow drops the beat and sticks
      tick();
      fill4();
      push_beat(8'h77);
      check("s4_usage", usage_o, 4);
      check("s4_overflow", overflow_o, 1);
      ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("s4_data", data_o, i);
         tick();
      end
      ready_i = 1'b0;
      check("s4_usage_end", usage_o, 0);
      check("s4_valid_end", valid_o, 0);
      tick();
      tick();
      check("s4_overflow_sticky", overflow_o, 1);

      // 5: streaming push+pop, pointers wrap five times
      do_reset();
      check("s5_overflow_cleared", overflow_o, 0);
      push_beat(8'h00);
      n_credits = 0;
      ready_i = 1'b1;
      valid_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         data_i = 8'(i);
         check("s5_data", data_o, i - 1);
         tick();
         check("s5_usage", usage_o, 1);
         if (credit_o) n_credits++;
      end
      valid_i = 1'b0;
      check("s5_credits", n_credits, 20);
      check("s5_last", data_o, 20);
      tick();
      ready_i = 1'b0;
      check("s5_usage_end", usage_o, 0);

      // 6: reset discards buffered beats, pending pop yields no credit
      push_beat(8'h10);
      push_beat(8'h11);
      push_beat(8'h12);
      check("s6_usage_pre", usage_o, 3);
      rst_i   = 1'b1;
      ready_i = 1'b1;
      tick();
      rst_i   = 1'b0;
      ready_i = 1'b0;
      check("s6_valid", valid_o, 0);
      check("s6_usage", usage_o, 0);
      check("s6_overflow", overflow_o, 0);
      check("s6_credit", credit_o, 0);
      tick();
      check("s6_credit_later", credit_o, 0);
      push_beat(8'h99);
      check("s6_valid_new", valid_o, 1);
      check("s6_data_new", data_o, 8'h99);
      check("s6_usage_new", usage_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
